// File: rtl/keypad_bcd_buffer_if.sv
// Key-line input, flush/handshake controls and buffered-code outputs of keypad_bcd_buffer.
// The design drives this bundle through the slave modport.
interface keypad_bcd_buffer_if #(
  parameter int unsigned KEYS   = 10,
  parameter int unsigned DIGITS = 4
);
  logic [KEYS-1:0]     d;
  logic                clear;
  logic                code_ready;
  logic                key_valid;
  logic [3:0]          key_bcd;
  logic [4*DIGITS-1:0] code;
  logic [3:0]          count;
  logic                code_valid;
  logic                overflow;
  logic                error;

  modport master (
    output d, clear, code_ready,
    input  key_valid, key_bcd, code, count, code_valid, overflow, error
  );

  modport slave (
    input  d, clear, code_ready,
    output key_valid, key_bcd, code, count, code_valid, overflow, error
  );
endinterface

// File: rtl/keypad_bcd_buffer.sv
// Debounces one-hot keypad lines and shifts accepted key indices into a BCD digit buffer
// (the newest digit is in nibble 0). It flags multi-hot input and keys dropped when the buffer is full or flushed.
module keypad_bcd_buffer #(
  parameter int unsigned KEYS          = 10,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  keypad_bcd_buffer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  state_t              state;
  logic [KEYS-1:0]     cand;
  logic [7:0]          stab;
  logic                key_valid_r;
  logic [3:0]          key_bcd_r;
  logic                error_r;
  logic                overflow_r;
  logic [4*DIGITS-1:0] code_r;
  logic [3:0]          count_r;

  logic                d_zero;
  logic                d_onehot;
  logic                d_match;
  logic                accept;
  logic                full;
  logic                flush;
  logic [3:0]          cand_idx;

  always_comb begin
    d_zero   = (bus.d == '0);
    d_onehot = !d_zero && ((bus.d & (bus.d - KEYS'(1))) == '0);
    d_match  = (bus.d == cand);
    // The edge that would bring the count to STABLE_CYCLES is the acceptance edge.
    accept   = (state == DEBOUNCE) && d_match && (stab == 8'(STABLE_CYCLES - 1));
    full     = (count_r == 4'(DIGITS));
    flush    = bus.clear || (full && bus.code_ready);
    cand_idx = '0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (cand[i]) cand_idx = 4'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      stab        <= '0;
      key_valid_r <= 1'b0;
      key_bcd_r   <= '0;
      error_r     <= 1'b0;
    end else begin
      key_valid_r <= accept;
      error_r     <= 1'b0;
      if (accept) key_bcd_r <= cand_idx;
      case (state)
        IDLE: begin
          if (d_onehot) begin
            cand  <= bus.d;
            stab  <= 8'd1;
            state <= DEBOUNCE;
          end else if (!d_zero) begin
            error_r <= 1'b1;
            state   <= HELD;
          end
        end
        DEBOUNCE: begin
          if (!d_match)    state <= IDLE;
          else if (accept) state <= HELD;
          else             stab  <= stab + 8'd1;
        end
        HELD: begin
          if (d_zero) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      // A flush on the acceptance edge discards the key, so it counts as a drop.
      overflow_r <= accept && (flush || full);
      if (flush) begin
        code_r  <= '0;
        count_r <= '0;
      end else if (accept && !full) begin
        code_r  <= (code_r << 4) | (4*DIGITS)'(cand_idx);
        count_r <= count_r + 4'd1;
      end
    end
  end

  assign bus.key_valid  = key_valid_r;
  assign bus.key_bcd    = key_bcd_r;
  assign bus.code       = code_r;
  assign bus.count      = count_r;
  assign bus.code_valid = full;
  assign bus.overflow   = overflow_r;
  assign bus.error      = error_r;

endmodule

// File: tb/tb_keypad_bcd_buffer.sv
// Bench for keypad_bcd_buffer: a queue-based reference model is compared every cycle,
// plus literal expectations for the documented scenarios and a randomized run.
module tb_keypad_bcd_buffer;
  localparam int unsigned KEYS   = 10;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_bcd_buffer_if #(.KEYS(KEYS), .DIGITS(DIGITS)) kp ();

  keypad_bcd_buffer #(.KEYS(KEYS), .DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (kp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain flags and counters, with the digit buffer held as a queue.
  bit              m_valid = 0;
  bit              wait_release;
  int              run_len;
  logic [KEYS-1:0] run_key;
  int              digits[$];
  bit              e_kv, e_ov, e_err;
  int              e_bcd;

  function automatic int key_index(logic [KEYS-1:0] v);
    int r = 0;
    for (int i = 0; i < KEYS; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic cmp(string name, int unsigned act, int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc = 0;
    bit flush;
    if (rst) begin
      wait_release = 0; run_len = 0; run_key = '0;
      digits.delete();
      e_kv = 0; e_ov = 0; e_err = 0; e_bcd = 0;
      m_valid = 1;
      return;
    end
    e_kv = 0; e_ov = 0; e_err = 0;
    if (wait_release) begin
      if (kp.d == '0) wait_release = 0;
    end else if (run_len > 0) begin
      if (kp.d == run_key) begin
        run_len++;
        if (run_len == STABLE) begin acc = 1; run_len = 0; wait_release = 1; end
      end else run_len = 0;
    end else if (kp.d != '0) begin
      if ($countones(kp.d) == 1) begin run_key = kp.d; run_len = 1; end
      else begin e_err = 1; wait_release = 1; end
    end
    if (acc) begin e_kv = 1; e_bcd = key_index(run_key); end
    flush = kp.clear || (digits.size() == DIGITS && kp.code_ready);
    if (flush) begin
      digits.delete();
      if (acc) e_ov = 1;
    end else if (acc) begin
      if (digits.size() < DIGITS) digits.push_back(e_bcd);
      else e_ov = 1;
    end
  endtask

  task automatic check_all();
    int unsigned e_code = 0;
    foreach (digits[j]) e_code = e_code | (digits[j] << (4 * (digits.size() - 1 - j)));
    cmp("key_valid",  kp.key_valid, e_kv);
    cmp("key_bcd",    kp.key_bcd, e_bcd);
    cmp("code",       kp.code, e_code);
    cmp("count",      kp.count, digits.size());
    cmp("code_valid", kp.code_valid, digits.size() == DIGITS);
    cmp("overflow",   kp.overflow, e_ov);
    cmp("error",      kp.error, e_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_valid) check_all();
  endtask

  task automatic do_reset();
    rst = 1; kp.d = '0; kp.clear = 0; kp.code_ready = 0;
    step(); step();
    rst = 0;
  endtask

  int kv_cnt, kv_at, ov_cnt, er_cnt;
  int keys4[4] = '{1, 9, 0, 7};

  initial begin
    kp.d = '0; kp.clear = 0; kp.code_ready = 0;
    do_reset();
    cmp("reset_code", kp.code, 0);
    cmp("reset_count", kp.count, 0);
    cmp("reset_kv", kp.key_valid, 0);

    // Single key
    kv_cnt = 0; kv_at = -1;
    kp.d = 10'h020;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (kp.key_valid) begin kv_cnt++; if (kv_at < 0) kv_at = i; end
    end
    kp.d = '0; step();
    cmp("single_pulses", kv_cnt, 1);
    cmp("single_latency", kv_at, 3);
    cmp("single_bcd", kp.key_bcd, 5);
    cmp("single_code", kp.code, 16'h0005);
    cmp("single_count", kp.count, 1);

    // Bounce
    do_reset();
    kp.d = 10'h004; step(); step();
    kp.d = '0; step();
    kp.d = 10'h004; kv_cnt = 0; kv_at = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (kp.key_valid) begin kv_cnt++; if (kv_at < 0) kv_at = i; end
    end
    kp.d = '0; step();
    cmp("bounce_pulses", kv_cnt, 1);
    cmp("bounce_latency", kv_at, 3);
    cmp("bounce_bcd", kp.key_bcd, 2);

    // Fill, overflow, handshake
    do_reset();
    foreach (keys4[k]) begin
      kp.d = '0; kp.d[keys4[k]] = 1'b1;
      repeat (4) step();
      kp.d = '0; repeat (2) step();
    end
    cmp("fill_code", kp.code, 16'h1907);
    cmp("fill_count", kp.count, 4);
    cmp("fill_valid", kp.code_valid, 1);
    ov_cnt = 0;
    kp.d = 10'h008;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) kp.d = '0;
      step();
      if (kp.overflow) ov_cnt++;
    end
    cmp("ovf_pulses", ov_cnt, 1);
    cmp("ovf_code", kp.code, 16'h1907);
    cmp("ovf_bcd", kp.key_bcd, 3);
    kp.code_ready = 1; step(); kp.code_ready = 0;
    cmp("hs_code", kp.code, 0);
    cmp("hs_count", kp.count, 0);
    cmp("hs_valid", kp.code_valid, 0);

    // Multi-hot
    do_reset();
    er_cnt = 0; kv_cnt = 0;
    kp.d = 10'h081;
    for (int i = 0; i < 4; i++) begin
      step();
      if (kp.error) er_cnt++;
      if (kp.key_valid) kv_cnt++;
    end
    cmp("multi_err", er_cnt, 1);
    cmp("multi_kv", kv_cnt, 0);
    cmp("multi_count", kp.count, 0);
    kp.d = '0; step();

    // Collision with clear
    do_reset();
    kp.d = 10'h040; step(); step();
    kp.clear = 1; step(); kp.clear = 0;
    cmp("coll_kv", kp.key_valid, 1);
    cmp("coll_ov", kp.overflow, 1);
    cmp("coll_code", kp.code, 0);
    cmp("coll_count", kp.count, 0);
    kp.d = '0; step();

    // Reset mid-debounce, then re-debounce of the still-held key
    do_reset();
    kp.d = 10'h010; step();
    rst = 1; step(); rst = 0;
    cmp("rst_kv", kp.key_valid, 0);
    cmp("rst_bcd", kp.key_bcd, 0);
    cmp("rst_code", kp.code, 0);
    cmp("rst_ovf_err", {kp.overflow, kp.error}, 0);
    kv_at = -1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (kp.key_valid && kv_at < 0) kv_at = i;
    end
    cmp("rst_redebounce", kv_at, 3);
    kp.d = '0; step();

    // Randomized runs
    for (int r = 0; r < 400; r++) begin
      int sel = $urandom_range(0, 9);
      int len = $urandom_range(1, 6);
      if (sel < 2) kp.d = '0;
      else if (sel < 8) begin kp.d = '0; kp.d[$urandom_range(0, KEYS - 1)] = 1'b1; end
      else begin
        int b1 = $urandom_range(0, KEYS - 1);
        int b2 = (b1 + 1 + $urandom_range(0, KEYS - 2)) % KEYS;
        kp.d = '0; kp.d[b1] = 1'b1; kp.d[b2] = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        kp.clear      = ($urandom_range(0, 19) == 0);
        kp.code_ready = ($urandom_range(0, 3) == 0);
        rst           = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    rst = 0; kp.clear = 0; kp.code_ready = 0; kp.d = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
